// File: rtl/nn_pkg.sv
// Shared definitions for the nn feature buffers and pooling sequencer:
// layer codes, data width, sequencer states and per-layer pooled geometry.
package nn_pkg;

    localparam int DATSIZE = 22;
    localparam int CNTW    = 6;

    localparam logic [3:0] LAYER_POOL1 = 4'b0011;
    localparam logic [3:0] LAYER_POOL2 = 4'b0101;
    localparam logic [3:0] LAYER_POOL3 = 4'b0111;

    typedef enum logic [2:0] {
        IDLE,
        RD_UP,
        RD_DN,
        EMIT,
        HOLD,
        DONE
    } pool_state_e;

    // Last valid index of each pooled dimension (size minus one).
    typedef struct packed {
        logic [CNTW-1:0] y_last;
        logic [CNTW-1:0] x_last;
        logic [CNTW-1:0] c_last;
    } pool_geom_t;

    function automatic logic layer_is_pool(input logic [3:0] code);
        return (code == LAYER_POOL1) || (code == LAYER_POOL2) || (code == LAYER_POOL3);
    endfunction

    function automatic pool_geom_t pool_geom(input logic [3:0] code);
        pool_geom_t g;
        g = '0;
        case (code)
            LAYER_POOL1: begin
                g.y_last = 6'd15;
                g.x_last = 6'd15;
                g.c_last = 6'd15;
            end
            LAYER_POOL2: begin
                g.y_last = 6'd7;
                g.x_last = 6'd7;
                g.c_last = 6'd31;
            end
            LAYER_POOL3: begin
                g.y_last = 6'd3;
                g.x_last = 6'd3;
                g.c_last = 6'd63;
            end
            default: g = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/pool_seq_max4.sv
// Two-stage signed max over a 2x2 window: the up-row pair max is held
// after the up read, and the final max is registered after the down read.
module pool_seq_max4
    import nn_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      up_vld,
    input  logic                      dn_vld,
    input  logic [2*DATSIZE-1:0]      rd_data,
    output logic signed [DATSIZE-1:0] max_out
);

    logic signed [DATSIZE-1:0] lo_val;
    logic signed [DATSIZE-1:0] hi_val;
    logic signed [DATSIZE-1:0] pair_max;
    logic signed [DATSIZE-1:0] pair_q;
    logic signed [DATSIZE-1:0] pair_d;
    logic signed [DATSIZE-1:0] res_q;
    logic signed [DATSIZE-1:0] res_d;

    // Max of the two columns currently on the read bus.
    always_comb begin
        lo_val   = $signed(rd_data[DATSIZE-1:0]);
        hi_val   = $signed(rd_data[2*DATSIZE-1:DATSIZE]);
        pair_max = (hi_val > lo_val) ? hi_val : lo_val;
    end

    // Capture the up pair, then fold the down pair into the held result.
    always_comb begin
        pair_d = pair_q;
        res_d  = res_q;
        if (up_vld) begin
            pair_d = pair_max;
        end
        if (dn_vld) begin
            res_d = (pair_max > pair_q) ? pair_max : pair_q;
        end
    end

    // Stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pair_q <= '0;
            res_q  <= '0;
        end else begin
            pair_q <= pair_d;
            res_q  <= res_d;
        end
    end

    assign max_out = res_q;

endmodule

// File: rtl/pool_seq.sv
// 2x2 max-pooling sequencer: walks the pooled output volume (c, y, x),
// issues up/down row reads, and writes results (POOL1/POOL2) or streams
// them through a valid/ready handshake (POOL3).
module pool_seq
    import nn_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [3:0]                layer,
    output logic                      rd_en,
    output logic [5:0]                rd_y,
    output logic [5:0]                rd_x,
    output logic [5:0]                rd_c,
    output logic                      rd_updown,
    input  logic [2*DATSIZE-1:0]      rd_data,
    output logic                      wr_en,
    output logic [4:0]                wr_y,
    output logic [4:0]                wr_x,
    output logic [4:0]                wr_c,
    output logic signed [DATSIZE-1:0] wr_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [DATSIZE-1:0] out_data,
    output logic                      busy,
    output logic                      done
);

    pool_state_e state_q;
    pool_state_e state_d;

    logic [3:0]      layer_q;
    logic [3:0]      layer_d;
    logic [CNTW-1:0] y_q;
    logic [CNTW-1:0] y_d;
    logic [CNTW-1:0] x_q;
    logic [CNTW-1:0] x_d;
    logic [CNTW-1:0] c_q;
    logic [CNTW-1:0] c_d;
    logic            last_q;
    logic            last_d;
    logic            done_q;
    logic            done_d;

    logic            up_vld_q;
    logic            up_vld_d;
    logic            dn_vld_q;
    logic            dn_vld_d;
    logic [4:0]      pa_y_q;
    logic [4:0]      pa_y_d;
    logic [4:0]      pa_x_q;
    logic [4:0]      pa_x_d;
    logic [4:0]      pa_c_q;
    logic [4:0]      pa_c_d;
    logic            wr_en_q;
    logic            wr_en_d;
    logic [4:0]      wr_y_q;
    logic [4:0]      wr_y_d;
    logic [4:0]      wr_x_q;
    logic [4:0]      wr_x_d;
    logic [4:0]      wr_c_q;
    logic [4:0]      wr_c_d;

    pool_geom_t                geom;
    logic                      is_pool3;
    logic                      at_last;
    logic                      reading;
    logic signed [DATSIZE-1:0] max_res;

    assign geom     = pool_geom(layer_q);
    assign is_pool3 = (layer_q == LAYER_POOL3);
    assign at_last  = (x_q == geom.x_last) && (y_q == geom.y_last) && (c_q == geom.c_last);
    assign reading  = (state_q == RD_UP) || (state_q == RD_DN);

    pool_seq_max4 u_max4 (
        .clk     (clk),
        .rst     (rst),
        .up_vld  (up_vld_q),
        .dn_vld  (dn_vld_q),
        .rd_data (rd_data),
        .max_out (max_res)
    );

    // Sequencer: read pairs back to back for POOL1/POOL2, one window at a
    // time with a handshake hold for POOL3, then a single done pulse.
    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        y_d     = y_q;
        x_d     = x_q;
        c_d     = c_q;
        last_d  = last_q;
        done_d  = 1'b0;
        pa_y_d  = pa_y_q;
        pa_x_d  = pa_x_q;
        pa_c_d  = pa_c_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (layer_is_pool(layer)) begin
                        state_d = RD_UP;
                        layer_d = layer;
                        y_d     = '0;
                        x_d     = '0;
                        c_d     = '0;
                        last_d  = 1'b0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RD_UP: begin
                state_d = RD_DN;
            end
            RD_DN: begin
                pa_y_d = y_q[4:0];
                pa_x_d = x_q[4:0];
                pa_c_d = c_q[4:0];
                last_d = at_last;
                if (x_q == geom.x_last) begin
                    x_d = '0;
                    if (y_q == geom.y_last) begin
                        y_d = '0;
                        c_d = (c_q == geom.c_last) ? '0 : c_q + 6'd1;
                    end else begin
                        y_d = y_q + 6'd1;
                    end
                end else begin
                    x_d = x_q + 6'd1;
                end
                state_d = (at_last || is_pool3) ? EMIT : RD_UP;
            end
            EMIT: begin
                state_d = is_pool3 ? HOLD : DONE;
            end
            HOLD: begin
                if (out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RD_UP;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Data-return pipeline: flag which row arrives next cycle and turn a
    // completed down read into a write two cycles after it was issued.
    always_comb begin
        up_vld_d = (state_q == RD_UP);
        dn_vld_d = (state_q == RD_DN);
        wr_en_d  = dn_vld_q && !is_pool3;
        wr_y_d   = wr_en_d ? pa_y_q : 5'd0;
        wr_x_d   = wr_en_d ? pa_x_q : 5'd0;
        wr_c_d   = wr_en_d ? pa_c_q : 5'd0;
    end

    // State, counters and pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            layer_q  <= '0;
            y_q      <= '0;
            x_q      <= '0;
            c_q      <= '0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            up_vld_q <= 1'b0;
            dn_vld_q <= 1'b0;
            pa_y_q   <= '0;
            pa_x_q   <= '0;
            pa_c_q   <= '0;
            wr_en_q  <= 1'b0;
            wr_y_q   <= '0;
            wr_x_q   <= '0;
            wr_c_q   <= '0;
        end else begin
            state_q  <= state_d;
            layer_q  <= layer_d;
            y_q      <= y_d;
            x_q      <= x_d;
            c_q      <= c_d;
            last_q   <= last_d;
            done_q   <= done_d;
            up_vld_q <= up_vld_d;
            dn_vld_q <= dn_vld_d;
            pa_y_q   <= pa_y_d;
            pa_x_q   <= pa_x_d;
            pa_c_q   <= pa_c_d;
            wr_en_q  <= wr_en_d;
            wr_y_q   <= wr_y_d;
            wr_x_q   <= wr_x_d;
            wr_c_q   <= wr_c_d;
        end
    end

    assign rd_en     = reading;
    assign rd_updown = (state_q == RD_DN);
    assign rd_y      = reading ? y_q : 6'd0;
    assign rd_x      = reading ? x_q : 6'd0;
    assign rd_c      = reading ? c_q : 6'd0;
    assign wr_en     = wr_en_q;
    assign wr_y      = wr_y_q;
    assign wr_x      = wr_x_q;
    assign wr_c      = wr_c_q;
    assign wr_data   = wr_en_q ? max_res : '0;
    assign out_valid = (state_q == HOLD);
    assign out_data  = (state_q == HOLD) ? max_res : '0;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule
